// File: rtl/icache_frontend_if.sv
// Fetch-side and memory-side signal bundle for icache_frontend.
// slave is the cache view; master is the datapath/memory-controller view.
interface icache_frontend_if #(
  parameter int WORD_W = 32
);
  logic              imemREN;
  logic [31:0]       imemaddr;
  logic [WORD_W-1:0] imemload;
  logic              ihit;
  logic              flush;
  logic              iREN;
  logic [31:0]       iaddr;
  logic [WORD_W-1:0] iload;
  logic              iwait;

  modport slave (
    input  imemREN, imemaddr, flush, iload, iwait,
    output imemload, ihit, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, flush, iload, iwait,
    input  imemload, ihit, iREN, iaddr
  );
endinterface

// File: rtl/icache_frontend.sv
// Direct-mapped, one-word-block instruction cache with a two-state miss-fill FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_frontend #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  icache_frontend_if.slave   bus,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic {IDLE, FETCH} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  word_t            r_data [SETS];
  logic [31:2]      r_miss_addr;

  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_miss;
  logic             w_fill;
  logic             w_unused;

  assign w_idx      = bus.imemaddr[IDX_W+1:2];
  assign w_tag      = bus.imemaddr[31:IDX_W+2];
  assign w_fill_idx = r_miss_addr[IDX_W+1:2];
  assign w_unused   = ^bus.imemaddr[1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hit        = 1'b0;
    w_miss       = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.imemREN) begin
          if (r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !bus.flush) begin
            w_hit = 1'b1;
          end else begin
            w_miss       = 1'b1;
            w_state_next = FETCH;
          end
        end
      end
      FETCH: begin
        // A fill landing together with a flush is dropped; the FSM still returns.
        if (!bus.iwait) begin
          w_fill       = !bus.flush;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.ihit     = w_hit;
  assign bus.imemload = r_data[w_idx];
  assign bus.iREN     = (r_state == FETCH);
  assign bus.iaddr    = (r_state == FETCH) ? {r_miss_addr, 2'b00} : 32'h0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_miss_addr <= '0;
    end else if (w_miss) begin
      r_miss_addr <= bus.imemaddr[31:2];
    end
  end

  generate
    for (genvar gi = 0; gi < SETS; gi++) begin : g_frame
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_valid[gi] <= 1'b0;
          r_tag[gi]   <= '0;
          r_data[gi]  <= '0;
        end else if (bus.flush) begin
          r_valid[gi] <= 1'b0;
        end else if (w_fill && (w_fill_idx == IDX_W'(gi))) begin
          r_valid[gi] <= 1'b1;
          r_tag[gi]   <= r_miss_addr[31:IDX_W+2];
          r_data[gi]  <= bus.iload;
        end
      end
    end
  endgenerate

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit)  r_hit_count  <= r_hit_count + 32'd1;
      if (w_miss) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif
endmodule

// File: tb/tb_icache_frontend.sv
// Scoreboard bench for icache_frontend: stimulus pushes expected cycles,
// a negedge monitor pops one entry whenever the cache drives ihit/iREN or a probe.
module tb_icache_frontend;
  logic        CLK;
  logic        RST;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        probe;

  icache_frontend_if #(.WORD_W(32)) bus ();

  icache_frontend #(.SETS(16), .WORD_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    string       nm;
    logic        h;
    logic [31:0] d;
    logic        r;
    logic [31:0] a;
    logic [31:0] hc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   hc_model   = 0;
  int   mc_model   = 0;

  function automatic logic [31:0] stat(input int v);
`ifdef ICACHE_STATS_EN
    return 32'(v);
`else
    return (v == 0) ? 32'h0 : 32'h0;
`endif
  endfunction

  task automatic cyc(input logic ren, input logic [31:0] addr, input logic fl,
                     input logic wt, input logic [31:0] ld, input logic rst);
    @(posedge CLK);
    #1;
    probe        = 1'b0;
    RST          = rst;
    bus.imemREN  = ren;
    bus.imemaddr = addr;
    bus.flush    = fl;
    bus.iwait    = wt;
    bus.iload    = ld;
  endtask

  task automatic exp_out(input string nm, input logic h, input logic [31:0] d,
                         input logic r, input logic [31:0] a);
    exp_t e;
    e.nm = nm; e.h = h; e.d = d; e.r = r; e.a = a;
    e.hc = stat(hc_model);
    e.mc = stat(mc_model);
    q.push_back(e);
    if (h) hc_model++;
  endtask

  task automatic exp_probe(input string nm);
    probe = 1'b1;
    exp_out(nm, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Miss detected in IDLE (silent), optional wait cycles, fill, then a hit.
  task automatic fill(input logic [31:0] a, input int nwait, input logic [31:0] d);
    cyc(1, a, 0, 1, 32'h0, 0);
    mc_model++;
    for (int k = 0; k < nwait; k++) begin
      cyc(1, a, 0, 1, 32'h0, 0);
      exp_out("fill_wait", 0, 32'h0, 1, a);
    end
    cyc(1, a, 0, 0, d, 0);
    exp_out("fill_done", 0, 32'h0, 1, a);
    cyc(1, a, 0, 1, 32'h0, 0);
    exp_out("hit_after_fill", 1, d, 0, 32'h0);
  endtask

  always @(negedge CLK) begin
    if (bus.ihit || bus.iREN || probe) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_output: got ihit=%0b iREN=%0b iaddr=%h, required no output",
                 bus.ihit, bus.iREN, bus.iaddr);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.ihit !== e.h || (e.h && bus.imemload !== e.d) || bus.iREN !== e.r ||
            bus.iaddr !== e.a || hit_count !== e.hc || miss_count !== e.mc) begin
          mismatched++;
          $display("FAIL %s: got ihit=%0b load=%h iREN=%0b iaddr=%h hc=%0d mc=%0d, required ihit=%0b load=%h iREN=%0b iaddr=%h hc=%0d mc=%0d",
                   e.nm, bus.ihit, bus.imemload, bus.iREN, bus.iaddr, hit_count, miss_count,
                   e.h, e.d, e.r, e.a, e.hc, e.mc);
        end else begin
          $display("ok %s: ihit=%0b load=%h iREN=%0b iaddr=%h hc=%0d mc=%0d",
                   e.nm, bus.ihit, bus.imemload, bus.iREN, bus.iaddr, hit_count, miss_count);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    probe        = 1'b0;
    RST          = 1'b1;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0;
    bus.flush    = 1'b0;
    bus.iwait    = 1'b1;
    bus.iload    = 32'h0;
    repeat (3) @(posedge CLK);

    // Reset state
    cyc(0, 32'h0, 0, 1, 32'h0, 0);
    exp_probe("reset_state");

    // Cold miss with 3 stall cycles, then warm hits
    fill(32'h40, 3, 32'hDEADBEEF);
    cyc(1, 32'h40, 0, 1, 32'h0, 0);
    exp_out("warm_hit1", 1, 32'hDEADBEEF, 0, 32'h0);
    cyc(1, 32'h41, 0, 1, 32'h0, 0);
    exp_out("warm_hit_byteoff", 1, 32'hDEADBEEF, 0, 32'h0);
    cyc(0, 32'h40, 0, 1, 32'h0, 0);

    // Conflict eviction: 0x440 shares index 0, then 0x40 misses again
    fill(32'h440, 1, 32'h11111111);
    fill(32'h40, 0, 32'hCAFEF00D);

    // Redirect during fill: iaddr stays at 0x80, then 0x84 misses on its own
    cyc(1, 32'h80, 0, 1, 32'h0, 0);
    mc_model++;
    cyc(1, 32'h84, 0, 1, 32'h0, 0);
    exp_out("redirect_wait1", 0, 32'h0, 1, 32'h80);
    cyc(1, 32'h84, 0, 1, 32'h0, 0);
    exp_out("redirect_wait2", 0, 32'h0, 1, 32'h80);
    cyc(1, 32'h84, 0, 0, 32'h80808080, 0);
    exp_out("redirect_fill", 0, 32'h0, 1, 32'h80);
    cyc(1, 32'h84, 0, 1, 32'h0, 0);
    mc_model++;
    cyc(1, 32'h84, 0, 0, 32'h84848484, 0);
    exp_out("redirect_new_fill", 0, 32'h0, 1, 32'h84);
    cyc(1, 32'h84, 0, 1, 32'h0, 0);
    exp_out("redirect_new_hit", 1, 32'h84848484, 0, 32'h0);
    cyc(1, 32'h80, 0, 1, 32'h0, 0);
    exp_out("redirect_old_hit", 1, 32'h80808080, 0, 32'h0);

    // Flush in IDLE forces a miss on a resident address
    fill(32'h40, 1, 32'h40404040);
    cyc(1, 32'h40, 1, 1, 32'h0, 0);
    mc_model++;
    cyc(1, 32'h40, 0, 0, 32'h55555555, 0);
    exp_out("flush_refill", 0, 32'h0, 1, 32'h40);
    cyc(1, 32'h40, 0, 1, 32'h0, 0);
    exp_out("flush_refill_hit", 1, 32'h55555555, 0, 32'h0);

    // Flush coincident with fill completion discards the fill
    cyc(1, 32'hC0, 0, 1, 32'h0, 0);
    mc_model++;
    cyc(1, 32'hC0, 1, 0, 32'h77777777, 0);
    exp_out("flush_fill_collide", 0, 32'h0, 1, 32'hC0);
    cyc(1, 32'hC0, 0, 1, 32'h0, 0);
    mc_model++;
    cyc(1, 32'hC0, 0, 0, 32'h78787878, 0);
    exp_out("after_collide_fill", 0, 32'h0, 1, 32'hC0);
    cyc(1, 32'hC0, 0, 1, 32'h0, 0);
    exp_out("after_collide_hit", 1, 32'h78787878, 0, 32'h0);

    // Reset during FETCH abandons the fill and clears counters and frames
    cyc(1, 32'h100, 0, 1, 32'h0, 0);
    mc_model++;
    cyc(1, 32'h100, 0, 1, 32'h0, 0);
    exp_out("pre_rst_wait", 0, 32'h0, 1, 32'h100);
    cyc(1, 32'h100, 0, 1, 32'h0, 1);
    exp_out("rst_cycle_wait", 0, 32'h0, 1, 32'h100);
    hc_model = 0;
    mc_model = 0;
    cyc(0, 32'h0, 0, 1, 32'h0, 0);
    exp_probe("after_mid_rst");
    fill(32'hC0, 0, 32'h99999999);

    cyc(0, 32'h0, 0, 1, 32'h0, 0);
    repeat (2) @(posedge CLK);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: got %0d pending expectations, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/icache_frontend.md
# icache_frontend

Direct-mapped, one-word-block instruction cache between the datapath's instruction fetch port and the memory controller's instruction channel (iREN/iaddr/iload/iwait). It answers fetches combinationally on a hit. On a miss it runs a two-state fill FSM that holds iREN until iwait drops, then writes the frame. The memory controller therefore sees at most one outstanding instruction read, with an address that is stable for the whole request.

## Interface
Parameters:
- SETS, 16, number of frames; power of two, at least 2; IDX_W = log2(SETS)
- WORD_W, 32, word width (word_t)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, synchronous and active-high
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address; bits [1:0] ignored
- imemload  out  32  fetched instruction; valid when ihit=1
- ihit  out  1  fetch satisfied this cycle
- flush  in  1  invalidate all frames
- iREN  out  1  read request to the memory controller
- iaddr  out  32  read address to the memory controller
- iload  in  32  read data from the memory controller
- iwait  in  1  memory controller busy; data is valid when iwait=0 with iREN=1
- hit_count  out  32  hit counter (see Configuration)
- miss_count  out  32  miss counter (see Configuration)

## Operation
Address split:
- index = imemaddr[IDX_W+1:2]
- tag = imemaddr[31:IDX_W+2]
- Storage per frame: valid bit, tag, data word.

States:
- IDLE
  - ihit = imemREN && valid[index] && tag[index]==tag; imemload = data[index].
  - On imemREN with no hit: latch miss_addr = {imemaddr[31:2],2'b00}, go to FETCH.
  - With imemREN=0: ihit=0, no state change.
- FETCH
  - ihit=0; iREN=1; iaddr=miss_addr.
  - When iwait=0: write valid=1, tag and data=iload into frame miss_addr index, then go to IDLE.
  - Otherwise stay in FETCH.
- imemaddr changes during FETCH (branch redirect): the fill still completes at the latched miss_addr. IDLE then re-evaluates the new address.
- iREN=0 and iaddr=0 in IDLE.

Flush:
- flush=1 clears every valid bit at the edge.
- In IDLE, ihit is forced to 0 during the flush cycle.
- In FETCH, the fetch continues. If the fill completes in the same cycle as flush, the fill is discarded: the frame stays invalid and the FSM still returns to IDLE.

Reset:
- RST at the edge: state=IDLE, all valid=0, miss_addr=0, counters=0.
- Outputs after reset: ihit=0, iREN=0, iaddr=0.
- imemload is undefined while ihit=0 (drives data[index]; reset data is 0).
- RST during FETCH abandons the fill; iREN drops the next cycle.
- RST has priority over flush and fill.

## Timing
- Hit: zero-cycle, combinational from imemaddr to ihit/imemload in IDLE.
- Miss, with the miss detected in cycle 0:
  - iREN is asserted from cycle 1.
  - If iwait first samples 0 in cycle N (N≥1), the frame is written at the end of cycle N.
  - ihit=1 in cycle N+1 if the address is unchanged.
  - Minimum miss penalty is 2 cycles.
- iREN/iaddr are registered-state decodes and do not depend combinationally on imemaddr. This is required because the memory controller gives data-port priority and may stall iwait arbitrarily.
- Simultaneous events:
  - A fill and a hit to another index cannot coincide, because ihit=0 in FETCH.
  - A fill overwrites a valid frame with a different tag: this is the conflict eviction.

## Configuration
- ICACHE_STATS_EN defined:
  - hit_count increments every cycle ihit=1.
  - miss_count increments on each IDLE->FETCH transition.
  - Both are 32-bit, wrap modulo 2^32, and clear on RST; flush does not clear them.
- ICACHE_STATS_EN undefined: hit_count and miss_count are tied to 0 and no counter flops are built.

## Test plan
- Cold miss:
  - Stimulus: after RST, imemREN=1, imemaddr=0x00000040; hold iwait=1 for 3 cycles, then 0 with iload=0xDEADBEEF.
  - Response: iREN=1 and iaddr=0x40 from cycle 1; ihit=1 with imemload=0xDEADBEEF in the cycle after iwait=0; miss_count=1.
- Warm hit: re-fetch 0x40 -> ihit=1 in the same cycle, iREN=0, hit_count increments each hit cycle.
- Conflict eviction:
  - Stimulus: fill 0x40, then fetch 0x440 (same index, SETS=16) with iload=0x11111111.
  - Response: miss and fill; a subsequent fetch of 0x40 misses again.
- Redirect mid-fill:
  - Stimulus: miss on 0x80, change imemaddr to 0x84 while iwait=1.
  - Response: iaddr stays 0x80 until fill; then 0x84 misses with iaddr=0x84.
- Flush:
  - Stimulus: fill 0x40, then pulse flush.
  - Response: next fetch of 0x40 misses.
  - Stimulus: flush coincident with fill completion (iwait=0).
  - Response: that frame stays invalid.
- Reset mid-fetch: assert RST during FETCH with iwait=1 -> iREN=0, ihit=0 next cycle; counters 0; the previously filled address misses.
